prom_loader: RTL
================

PROM_LOADER -- requirements
Module: prom_loader

Interface
REQ-001 SHALL have parameter WORD_BYTES, default 2, meaning bytes per program word (1..4).
REQ-002 SHALL have parameter ROM_WORDS, default 8, meaning memory depth (power of two, 2..256).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_data_i  input  8  received byte from the UART.
REQ-006 SHALL have port rx_ready_i  input  1  one-cycle strobe: rx_data_i is valid this cycle.
REQ-007 SHALL have port read_addr_i  input  $clog2(ROM_WORDS)  CPU fetch word address.
REQ-008 SHALL have port read_data_o  output  8*WORD_BYTES  word at read_addr_i, combinational.
REQ-009 SHALL have port load_busy_o  output  1  high while a frame is in progress.
REQ-010 SHALL have port load_done_o  output  1  one-cycle pulse at frame completion.
REQ-011 SHALL have port checksum_error_o  output  1  sticky; last completed frame failed its checksum.

Function
REQ-012 SHALL accept frames of the form: start-address byte, length byte (words), length*WORD_BYTES data bytes, checksum byte.
REQ-013 SHALL consume a byte only in a cycle where rx_ready_i=1; all other cycles leave the state unchanged.
REQ-014 SHALL implement states IDLE -> LEN -> DATA -> CSUM -> IDLE, one byte per transition (DATA stays until the last data byte).
REQ-015 SHALL take the start address modulo ROM_WORDS (low address bits only).
REQ-016 SHALL assemble each word little-endian (first byte = bits 7:0) and write it on the same edge that accepts its last byte.
REQ-017 SHALL increment the write address after each word write, wrapping from ROM_WORDS-1 to 0.
REQ-018 SHALL, for length 0, go from LEN directly to CSUM and write nothing.
REQ-019 SHALL accumulate an 8-bit modulo-256 sum of every frame byte including the checksum byte; the frame is good iff the sum is 0.
REQ-020 SHALL, on the edge accepting the checksum byte, pulse load_done_o the following cycle and set checksum_error_o to the frame result.
REQ-021 SHALL clear checksum_error_o when the next frame's address byte is accepted.
REQ-022 SHALL keep data written by a bad frame (no rollback); only the flag reports it.
REQ-023 SHALL drive load_busy_o=1 in LEN, DATA and CSUM, and 0 in IDLE.
REQ-024 SHALL return old data on read_data_o for an address written this cycle; new data appears after the edge.

Reset
REQ-025 SHALL on reset force state IDLE, load_busy_o=0, load_done_o=0, checksum_error_o=0, write address 0, byte index 0, sum 0.
REQ-026 SHALL abandon a frame interrupted by reset with no done pulse; completed word writes remain.
REQ-027 SHALL not clear memory contents on reset; reset takes priority over a coincident rx_ready_i.

Configuration
REQ-028 SHALL with PROM_LOADER_CHECKSUM_EN defined implement CSUM state and checksum_error_o per REQ-019..021.
REQ-029 SHALL without PROM_LOADER_CHECKSUM_EN omit the checksum byte (DATA or zero-length LEN goes to IDLE and pulses done) and tie checksum_error_o to 0.

Structure
REQ-030 SHALL place the state enumeration and the frame header byte count constant in shared package prom_loader_pkg.
REQ-031 SHALL keep the memory array and FSM in one module; no sub-module.

Verification (WORD_BYTES=2, ROM_WORDS=8, checksum enabled)
REQ-032 SHALL cover: frame 02 02 34 12 78 56 E8 -> word2=0x1234, word3=0x5678, done pulse, error=0.
REQ-033 SHALL cover: frame 07 02 11 AA 22 BB cs -> words 7=0xAA11 and 0=0xBB22 (wrap), error=0.
REQ-034 SHALL cover: frame of REQ-032 with last byte E9 -> words written, done pulse, error=1; next address byte clears error.
REQ-035 SHALL cover: frame 0A 00 F6 -> nothing written, done pulse, error=0 (address 0x0A treated as 2).
REQ-036 SHALL cover: reset after the 4th byte of REQ-032 frame, then full REQ-033 frame -> no done for the first, word2 unchanged, REQ-033 result intact.
REQ-037 SHALL cover: rx_ready_i low with changing rx_data_i for 20 cycles mid-frame -> no state change.

Source files
------------

// File: rtl/prom_loader_pkg.sv
// Shared definitions for the UART program-memory loader: FSM states and frame layout.
package prom_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEN  = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } state_t;

    // Address byte plus length byte precede the payload of every frame.
    localparam int HEADER_BYTES = 2;

endpackage

// File: rtl/prom_loader.sv
// Loads program words into a small RAM from UART byte frames: addr, len, len*WORD_BYTES data, [checksum].
// The checksum byte and sticky error flag exist only when PROM_LOADER_CHECKSUM_EN is defined.
module prom_loader
    import prom_loader_pkg::*;
#(
    parameter int WORD_BYTES = 2,
    parameter int ROM_WORDS  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    rx_data_i,
    input  logic                          rx_ready_i,
    input  logic [$clog2(ROM_WORDS)-1:0]  read_addr_i,
    output logic [8*WORD_BYTES-1:0]       read_data_o,
    output logic                          load_busy_o,
    output logic                          load_done_o,
    output logic                          checksum_error_o,
    output state_t                        fsm_state
);

    localparam int AW = $clog2(ROM_WORDS);
    localparam int DW = 8 * WORD_BYTES;
    localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(WORD_BYTES - 1);

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   wr_addr;
    logic [BW-1:0]   byte_idx;
    logic [7:0]      words_left;
    logic [DW-1:0]   word_buf;
    logic [DW-1:0]   wr_word;
    logic            take;
    logic            mem_we;
    logic            frame_end;
    logic [DW-1:0]   mem [ROM_WORDS];

    // Handshake: rx_ready_i is a bare strobe with no back-pressure; a byte is consumed
    // in exactly the cycles where it is high, and reset wins over a coincident strobe.
    assign take = rx_ready_i & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        frame_end  = 1'b0;
        if (take) begin
            case (state)
                ST_IDLE: state_next = ST_LEN;
                ST_LEN: begin
                    if (rx_data_i == 8'd0) begin
`ifdef PROM_LOADER_CHECKSUM_EN
                        state_next = ST_CSUM;
`else
                        state_next = ST_IDLE;
                        frame_end  = 1'b1;
`endif
                    end else begin
                        state_next = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (byte_idx == LAST_IDX) begin
                        mem_we = 1'b1;
                        if (words_left == 8'd1) begin
`ifdef PROM_LOADER_CHECKSUM_EN
                            state_next = ST_CSUM;
`else
                            state_next = ST_IDLE;
                            frame_end  = 1'b1;
`endif
                        end
                    end
                end
                ST_CSUM: begin
                    state_next = ST_IDLE;
                    frame_end  = 1'b1;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // The final byte of a word lands in the top lane straight from the receiver.
    always_comb begin
        wr_word              = word_buf;
        wr_word[DW-1 -: 8]   = rx_data_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_addr     <= '0;
            byte_idx    <= '0;
            words_left  <= '0;
            word_buf    <= '0;
            load_done_o <= 1'b0;
        end else begin
            load_done_o <= frame_end;
            if (take) begin
                case (state)
                    ST_IDLE: begin
                        wr_addr  <= rx_data_i[AW-1:0];
                        byte_idx <= '0;
                    end
                    ST_LEN: words_left <= rx_data_i;
                    ST_DATA: begin
                        if (byte_idx == LAST_IDX) begin
                            byte_idx   <= '0;
                            wr_addr    <= wr_addr + 1'b1;
                            words_left <= words_left - 8'd1;
                        end else begin
                            word_buf[byte_idx*8 +: 8] <= rx_data_i;
                            byte_idx                  <= byte_idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PROM_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic [7:0] sum_next;
    logic       csum_err;

    assign sum_next = sum + rx_data_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum      <= 8'd0;
            csum_err <= 1'b0;
        end else if (take) begin
            case (state)
                ST_IDLE: begin
                    sum      <= rx_data_i;
                    csum_err <= 1'b0;
                end
                ST_LEN, ST_DATA: sum <= sum_next;
                ST_CSUM: begin
                    sum      <= sum_next;
                    csum_err <= (sum_next != 8'd0);
                end
                default: ;
            endcase
        end
    end

    assign checksum_error_o = csum_err;
`else
    assign checksum_error_o = 1'b0;
`endif

    // No reset on the array: program contents survive a loader reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= wr_word;
        end
    end

    assign read_data_o = mem[read_addr_i];
    assign load_busy_o = (state != ST_IDLE);
    assign fsm_state   = state;

endmodule
